// File: rtl/anc_seq_pkg.sv
// Shared types for the ANC per-sample frame sequencer: FSM states, stage
// indices and a one-hot helper used to build stage start pulses.
`timescale 1ns/1ps
package anc_seq_pkg;

    localparam int N_STAGES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STG_FILTER = 2'd0,
        STG_ERROR  = 2'd1,
        STG_ADAPT  = 2'd2,
        STG_OUTPUT = 2'd3
    } stage_t;

    function automatic logic [N_STAGES-1:0] stage_onehot(input stage_t stage);
        logic [N_STAGES-1:0] vec;
        vec = '0;
        vec[stage] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/anc_frame_sequencer_watchdog.sv
// Per-stage watchdog: counts cycles while a stage is outstanding and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
`timescale 1ns/1ps
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic run_in,
    output logic expired_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter parks at LAST so a stalled stage keeps reporting expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_in) begin
            cnt_d = '0;
        end else if (run_in && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_out = run_in && (cnt_q == LAST);

endmodule

// File: rtl/anc_frame_sequencer.sv
// Per-sample scheduler for the ANC datapath: issues FILTER, ERROR, ADAPT and
// OUTPUT in order, gates ADAPT, counts dropped ticks and guards each stage.
`timescale 1ns/1ps
module anc_frame_sequencer
    import anc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sample_tick_in,
    input  logic             adapt_en_in,
    input  logic             error_locked_in,
    input  logic             clear_in,
    input  logic [3:0]       stage_done_in,
    output logic [3:0]       stage_start_out,
    output logic             busy_out,
    output logic             frame_done_out,
    output logic             adapted_out,
    output logic [CNT_W-1:0] overrun_cnt_out,
    output logic [CNT_W-1:0] frame_cnt_out,
    output logic             timeout_out,
    output logic [1:0]       fault_stage_out
);

    state_t state_q, state_d;
    stage_t stage_q, stage_d;
    logic   adapt_q, adapt_d;
    logic [N_STAGES-1:0] start_q, start_d;
    logic   busy_q, busy_d;
    logic   frame_done_q, frame_done_d;
    logic   adapted_q, adapted_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic   timeout_q, timeout_d;
    logic [1:0] fault_stage_q, fault_stage_d;

    logic wd_clear;
    logic wd_run;
    logic wd_expired;
    logic done_hit;

    assign wd_clear = (state_q == ISSUE);
    assign wd_run   = (state_q == WAIT);
    assign done_hit = stage_done_in[stage_q];

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (wd_clear),
        .run_in     (wd_run),
        .expired_out(wd_expired)
    );

    // Start and busy are derived from the next state so they line up with it.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        adapt_d       = adapt_q;
        frame_done_d  = 1'b0;
        adapted_d     = adapted_q;
        overrun_d     = overrun_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_d     = timeout_q;
        fault_stage_d = fault_stage_q;

        unique case (state_q)
            IDLE: begin
                if (sample_tick_in) begin
                    stage_d = STG_FILTER;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done_hit) begin
                    state_d = ISSUE;
                    unique case (stage_q)
                        STG_FILTER: stage_d = STG_ERROR;
                        STG_ERROR: begin
                            adapt_d = adapt_en_in & ~error_locked_in;
                            stage_d = (adapt_en_in & ~error_locked_in) ? STG_ADAPT : STG_OUTPUT;
                        end
                        STG_ADAPT: stage_d = STG_OUTPUT;
                        STG_OUTPUT: begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                            adapted_d    = adapt_q;
                        end
                    endcase
                end else if (wd_expired) begin
                    state_d       = FAULT;
                    timeout_d     = 1'b1;
                    fault_stage_d = stage_q;
                end
            end
            FAULT: begin
                if (clear_in) begin
                    state_d       = IDLE;
                    timeout_d     = 1'b0;
                    fault_stage_d = 2'd0;
                end
            end
        endcase

        if (sample_tick_in && ((state_q == ISSUE) || (state_q == WAIT)) && (overrun_q != '1)) begin
            overrun_d = overrun_q + CNT_W'(1);
        end

        start_d = (state_d == ISSUE) ? stage_onehot(stage_d) : '0;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            stage_q       <= STG_FILTER;
            adapt_q       <= 1'b0;
            start_q       <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            adapted_q     <= 1'b0;
            overrun_q     <= '0;
            frame_cnt_q   <= '0;
            timeout_q     <= 1'b0;
            fault_stage_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            adapt_q       <= adapt_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            adapted_q     <= adapted_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_q     <= timeout_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign stage_start_out = start_q;
    assign busy_out        = busy_q;
    assign frame_done_out  = frame_done_q;
    assign adapted_out     = adapted_q;
    assign overrun_cnt_out = overrun_q;
    assign frame_cnt_out   = frame_cnt_q;
    assign timeout_out     = timeout_q;
    assign fault_stage_out = fault_stage_q;

endmodule

// File: tb/tb_anc_frame_sequencer.sv
// Scoreboard bench for anc_frame_sequencer: each accepted tick is planned as
// a whole frame (start/done cycles, adapt decision, faults) and checked by a monitor.
`timescale 1ns/1ps
module tb_anc_frame_sequencer;

    localparam int TMO      = 16;
    localparam int CW       = 5;
    localparam int CNT_MAX  = (1 << CW) - 1;
    localparam int END_RAND = 2800;
    localparam int RST_CYC  = 2900;
    localparam int TOTAL    = 2960;
    localparam int MAXC     = 3100;

    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_TMO   = 2;
    localparam int EV_CLR   = 3;

    typedef struct {
        int cyc;
        int kind;
        int stage;
        int cnt;
        bit adapted;
    } ev_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          sample_tick_in = 1'b0;
    logic          adapt_en_in = 1'b0;
    logic          error_locked_in = 1'b0;
    logic          clear_in = 1'b0;
    logic [3:0]    stage_done_in = 4'd0;
    logic [3:0]    stage_start_out;
    logic          busy_out;
    logic          frame_done_out;
    logic          adapted_out;
    logic [CW-1:0] overrun_cnt_out;
    logic [CW-1:0] frame_cnt_out;
    logic          timeout_out;
    logic [1:0]    fault_stage_out;

    anc_frame_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_tick_in (sample_tick_in),
        .adapt_en_in    (adapt_en_in),
        .error_locked_in(error_locked_in),
        .clear_in       (clear_in),
        .stage_done_in  (stage_done_in),
        .stage_start_out(stage_start_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .adapted_out    (adapted_out),
        .overrun_cnt_out(overrun_cnt_out),
        .frame_cnt_out  (frame_cnt_out),
        .timeout_out    (timeout_out),
        .fault_stage_out(fault_stage_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;
    ev_t evQ[$];
    bit [3:0] doneAt[MAXC];
    bit       clearAt[MAXC];
    bit       adaptFix[MAXC];
    bit [1:0] adaptPair[MAXC];
    int       expOvr[MAXC];
    int ovr = 0;
    int frames = 0;
    int frameEnd = -1;
    int faultStart = -1;
    int faultEnd = -1;
    bit monOn = 1'b0;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void pushEv(input int c, input int kind, input int stage, input int cnt, input bit adapted);
        ev_t e;
        e.cyc = c;
        e.kind = kind;
        e.stage = stage;
        e.cnt = cnt;
        e.adapted = adapted;
        evQ.push_back(e);
    endfunction

    // Sprinkle done strobes on bits other than the stage being waited for.
    task automatic addSpurious(input int a, input int b, input int k);
        int j;
        for (int c = a; c <= b; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                j = int'($urandom_range(0, 3));
                if (j != k) doneAt[c][j] = 1'b1;
            end
        end
    endtask

    // Whole-frame plan: stage k started at s finishes at s+lat, next starts one cycle later.
    task automatic planFrame(input int t, input int fixLat, input int adaptMode, input int withhold);
        int s, d, k, lat, tf, cc;
        bit ae, el, doAdapt, fin;
        s = t + 1;
        k = 0;
        doAdapt = 1'b0;
        fin = 1'b0;
        for (int step = 0; step < 4 && !fin; step++) begin
            pushEv(s, EV_START, k, 0, 1'b0);
            if (k == withhold) begin
                tf = s + TMO + 1;
                pushEv(tf, EV_TMO, k, 0, 1'b0);
                cc = tf + int'($urandom_range(1, 6));
                clearAt[cc] = 1'b1;
                pushEv(cc + 1, EV_CLR, 0, 0, 1'b0);
                addSpurious(s + 1, tf - 1, k);
                faultStart = tf;
                faultEnd = cc;
                frameEnd = cc;
                fin = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) doneAt[s][k] = 1'b1;
                lat = (fixLat > 0) ? fixLat : int'($urandom_range(1, 6));
                d = s + lat;
                addSpurious(s + 1, d - 1, k);
                doneAt[d][k] = 1'b1;
                if (k == 1) begin
                    case (adaptMode)
                        0: begin ae = 1'b0; el = 1'b0; end
                        1: begin ae = 1'b1; el = 1'b0; end
                        2: begin ae = 1'b1; el = 1'b1; end
                        default: begin
                            ae = 1'($urandom_range(0, 1));
                            el = ($urandom_range(0, 3) == 0);
                        end
                    endcase
                    adaptFix[d] = 1'b1;
                    adaptPair[d] = {ae, el};
                    doAdapt = ae & ~el;
                end
                if (k == 3) begin
                    frames++;
                    pushEv(d + 1, EV_DONE, 3, frames & CNT_MAX, doAdapt);
                    frameEnd = d;
                    fin = 1'b1;
                end else begin
                    k = (k == 1) ? (doAdapt ? 2 : 3) : k + 1;
                    s = d + 1;
                end
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stage_start"}, int'(stage_start_out), 0);
        checkOutput({tag, "_busy"}, int'(busy_out), 0);
        checkOutput({tag, "_frame_done"}, int'(frame_done_out), 0);
        checkOutput({tag, "_adapted"}, int'(adapted_out), 0);
        checkOutput({tag, "_overrun_cnt"}, int'(overrun_cnt_out), 0);
        checkOutput({tag, "_frame_cnt"}, int'(frame_cnt_out), 0);
        checkOutput({tag, "_timeout"}, int'(timeout_out), 0);
        checkOutput({tag, "_fault_stage"}, int'(fault_stage_out), 0);
    endtask

    // Decide this cycle's tick, update the frame-level model, drive the inputs.
    task automatic applyStimulus(input int n);
        bit tick;
        int lat, am, wh;
        tick = 1'b0;
        lat = 0;
        am = -1;
        wh = -1;
        if (n < 300) begin
            case (n)
                10:  begin tick = 1'b1; lat = 4; am = 1; end
                40:  begin tick = 1'b1; lat = 4; am = 0; end
                70:  begin tick = 1'b1; lat = 4; am = 2; end
                100: begin tick = 1'b1; lat = 4; am = 1; wh = 1; end
                124: tick = 1'b1;
                140: tick = 1'b1;
                default: begin
                    if (n >= 200 && (n % 10) == 0) begin
                        tick = 1'b1;
                        lat = 6;
                        am = 1;
                    end
                end
            endcase
        end else if (n < END_RAND) begin
            tick = ($urandom_range(0, 5) == 0);
            wh = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1;
        end else if (n == RST_CYC - 8) begin
            tick = 1'b1;
            lat = 12;
            am = 1;
        end else if (n == RST_CYC + 6) begin
            tick = 1'b1;
        end

        if (tick) begin
            if (n > frameEnd) begin
                planFrame(n, lat, am, wh);
            end else if (!(n >= faultStart && n <= faultEnd) && ovr < CNT_MAX) begin
                ovr++;
            end
        end
        expOvr[n + 1] = ovr;

        sample_tick_in = tick;
        stage_done_in = doneAt[n];
        clear_in = clearAt[n];
        if (adaptFix[n]) begin
            {adapt_en_in, error_locked_in} = adaptPair[n];
        end else begin
            adapt_en_in = 1'($urandom_range(0, 1));
            error_locked_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic popExpect(input int kind, input int n, output ev_t e, output bit ok);
        ok = 1'b0;
        e.cyc = -1;
        e.kind = -1;
        e.stage = 0;
        e.cnt = 0;
        e.adapted = 1'b0;
        if (evQ.size() == 0) begin
            checkOutput("unexpected_event", kind, -1);
        end else begin
            e = evQ.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_cycle", n, e.cyc);
            ok = 1'b1;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        bit prevTo;
        bit ok;
        ev_t e;
        int n;
        prevTo = 1'b0;
        forever begin
            @(posedge clk_in);
            #2;
            n = cyc;
            if (!monOn || !rst_in) begin
                prevTo = 1'b0;
            end else begin
                if (stage_start_out != 4'd0) begin
                    popExpect(EV_START, n, e, ok);
                    if (ok) begin
                        checkOutput("start_onehot", int'(stage_start_out), 1 << e.stage);
                        checkOutput("busy_during_frame", int'(busy_out), 1);
                        checkOutput("overrun_cnt", int'(overrun_cnt_out), expOvr[n]);
                    end
                end
                if (frame_done_out) begin
                    popExpect(EV_DONE, n, e, ok);
                    if (ok) begin
                        checkOutput("frame_cnt", int'(frame_cnt_out), e.cnt);
                        checkOutput("adapted", int'(adapted_out), int'(e.adapted));
                        checkOutput("busy_after_frame", int'(busy_out), 0);
                        checkOutput("overrun_cnt", int'(overrun_cnt_out), expOvr[n]);
                    end
                end
                if (timeout_out && !prevTo) begin
                    popExpect(EV_TMO, n, e, ok);
                    if (ok) checkOutput("fault_stage", int'(fault_stage_out), e.stage);
                end
                if (!timeout_out && prevTo) begin
                    popExpect(EV_CLR, n, e, ok);
                    if (ok) checkOutput("fault_stage_cleared", int'(fault_stage_out), 0);
                end
                prevTo = timeout_out;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk_in);
        #1;
        checkAllZero("reset");
        @(negedge clk_in);
        rst_in = 1'b1;
        monOn = 1'b1;
        n = 0;
        while (n < TOTAL) begin
            @(posedge clk_in);
            #1;
            n = cyc;
            applyStimulus(n);
            if (n == RST_CYC) begin
                #2;
                rst_in = 1'b0;
                #1;
                checkAllZero("midreset");
                evQ.delete();
                for (int c = n + 1; c < MAXC; c++) begin
                    doneAt[c] = 4'd0;
                    clearAt[c] = 1'b0;
                    adaptFix[c] = 1'b0;
                end
                ovr = 0;
                frames = 0;
                frameEnd = -1;
                faultStart = -1;
                faultEnd = -1;
                expOvr[n + 1] = 0;
                sample_tick_in = 1'b0;
                stage_done_in = 4'd0;
                clear_in = 1'b0;
            end
            if (n == RST_CYC + 2) begin
                #3;
                rst_in = 1'b1;
            end
        end
        repeat (2) @(posedge clk_in);
        #3;
        checkOutput("pending_events", evQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
